// File: rtl/cfg_loader_pkg.sv
// Shared types and helpers for the configuration chain loader.
// Chain selection works on a per-chain "length is non-zero" mask.
package cfg_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERROR
    } state_e;

    localparam int unsigned MaxChains = 64;
    localparam int unsigned MaxIdxW   = 6;

    typedef struct packed {
        logic               found;
        logic [MaxIdxW-1:0] idx;
    } chain_sel_t;

    // Lowest chain index >= from_idx whose length is non-zero.
    function automatic chain_sel_t next_nonzero_chain(input logic [MaxChains-1:0] nz_mask,
                                                      input int unsigned from_idx);
        chain_sel_t sel;
        sel = '0;
        for (int unsigned i = 0; i < MaxChains; i++) begin
            if (!sel.found && i >= from_idx && nz_mask[i]) begin
                sel.found = 1'b1;
                sel.idx   = MaxIdxW'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Word buffer that accepts a stream word and emits it MSB-first, one bit per shift.
// Ready is offered on the last buffered bit as well, so consecutive words have no bubble.
module cfg_word_serializer #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              en_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              bit_o,
    output logic              avail_o,
    output logic              one_left_o
);
    localparam int unsigned CntW = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] buf_q, buf_d;
    logic [CntW-1:0]   buf_cnt_q, buf_cnt_d;

    assign avail_o    = (buf_cnt_q != '0);
    assign one_left_o = (buf_cnt_q == CntW'(1));
    assign bit_o      = buf_q[WORD_W-1];
    assign ready_o    = en_i && ((buf_cnt_q == '0) || (one_left_o && shift_i));

    always_comb begin
        buf_d     = buf_q;
        buf_cnt_d = buf_cnt_q;
        if (flush_i) begin
            buf_cnt_d = '0;
        end else if (valid_i && ready_o) begin
            buf_d     = data_i;
            buf_cnt_d = CntW'(WORD_W);
        end else if (shift_i && avail_o) begin
            buf_d     = buf_q << 1;
            buf_cnt_d = buf_cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q     <= '0;
            buf_cnt_q <= '0;
        end else begin
            buf_q     <= buf_d;
            buf_cnt_q <= buf_cnt_d;
        end
    end

endmodule

// File: rtl/cfg_chain_loader.sv
// Streams a packed bitstream into NUM_CHAINS daisy-chained config shift chains, one chain
// at a time, and drives the global prgm_b / done / err status.
module cfg_chain_loader
    import cfg_loader_pkg::*;
#(
    parameter int unsigned NUM_CHAINS = 4,
    parameter int unsigned WORD_W     = 8,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_start,
    input  logic                        cfg_abort,
    input  logic [NUM_CHAINS*LEN_W-1:0] chain_len,
    input  logic [WORD_W-1:0]           cfg_data,
    input  logic                        cfg_valid,
    input  logic                        cfg_last,
    output logic                        cfg_ready,
    output logic [NUM_CHAINS-1:0]       bit_out,
    output logic [NUM_CHAINS-1:0]       chain_shift,
    output logic                        prgm_b,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);
    localparam int unsigned IdxW = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;

    state_e                           state_q, state_d;
    logic [NUM_CHAINS-1:0][LEN_W-1:0] len_q, len_d;
    logic [IdxW-1:0]                  idx_q, idx_d;
    logic [LEN_W-1:0]                 cnt_q, cnt_d;
    logic                             last_q, last_d;
    logic                             done_q, done_d;

    logic                 ser_bit, ser_avail, ser_one_left, ser_en, ser_flush;
    logic                 shifting, chain_last_bit, finishing, run_dry, accepted;
    logic [LEN_W-1:0]     cur_len;
    logic [MaxChains-1:0] nz_cur, nz_new;
    chain_sel_t           nxt_sel, first_sel;

    cfg_word_serializer #(
        .WORD_W(WORD_W)
    ) u_serializer (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (ser_flush),
        .en_i      (ser_en),
        .shift_i   (shifting),
        .data_i    (cfg_data),
        .valid_i   (cfg_valid),
        .ready_o   (cfg_ready),
        .bit_o     (ser_bit),
        .avail_o   (ser_avail),
        .one_left_o(ser_one_left)
    );

    always_comb begin
        nz_cur = '0;
        nz_new = '0;
        for (int unsigned i = 0; i < NUM_CHAINS; i++) begin
            nz_cur[i] = |len_q[i];
            nz_new[i] = |chain_len[i*LEN_W +: LEN_W];
        end
        nxt_sel   = next_nonzero_chain(nz_cur, 32'(idx_q) + 32'd1);
        first_sel = next_nonzero_chain(nz_new, 32'd0);
    end

    assign cur_len        = len_q[idx_q];
    assign shifting       = (state_q == LOAD) && ser_avail && !cfg_abort;
    assign chain_last_bit = ((cnt_q + LEN_W'(1)) == cur_len);
    assign finishing      = shifting && chain_last_bit && !nxt_sel.found;
    // Final word fully consumed while some chain is still short of its length.
    assign run_dry        = shifting && ser_one_left && last_q && !finishing;
    assign ser_en         = (state_q == LOAD) && !cfg_abort && !last_q && !finishing;
    assign ser_flush      = (state_q != LOAD) || cfg_abort || finishing;
    assign accepted       = cfg_valid && cfg_ready;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        done_d  = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (cfg_abort) begin
                    state_d = ERROR;
                end else begin
                    if (accepted && cfg_last) last_d = 1'b1;
                    if (shifting) begin
                        if (chain_last_bit) begin
                            cnt_d = '0;
                            if (nxt_sel.found) begin
                                idx_d = IdxW'(nxt_sel.idx);
                            end else begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + LEN_W'(1);
                        end
                    end
                    if (run_dry) state_d = ERROR;
                end
            end
            default: begin
                if (cfg_start) begin
                    len_d  = chain_len;
                    cnt_d  = '0;
                    last_d = 1'b0;
                    idx_d  = IdxW'(first_sel.idx);
                    if (first_sel.found) begin
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        bit_out     = '0;
        chain_shift = '0;
        if (shifting) begin
            chain_shift[idx_q] = 1'b1;
            bit_out[idx_q]     = ser_bit;
        end
    end

    assign prgm_b = (state_q == DONE);
    assign busy   = (state_q == LOAD);
    assign err    = (state_q == ERROR);
    assign done   = done_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench for cfg_chain_loader: a bit-level model fills an expected queue as words
// are driven, and a negedge monitor pops it on every chain_shift cycle.
module tb_cfg_chain_loader;

    localparam logic [63:0] L1 = {16'd8, 16'd0, 16'd5, 16'd3};
    localparam logic [63:0] L3 = {16'd4, 16'd4, 16'd4, 16'd4};
    localparam logic [63:0] L6 = {16'd2, 16'd0, 16'd0, 16'd1};

    logic        clk, reset, cfg_start, cfg_abort, cfg_valid, cfg_last, cfg_ready;
    logic [63:0] chain_len;
    logic [7:0]  cfg_data;
    logic [3:0]  bit_out, chain_shift;
    logic        prgm_b, busy, done, err;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int mon_shifts = 0, mon_stalls = 0, last_shift_cyc = 0;
    int base_shifts = 0, base_stalls = 0;

    logic [2:0] exp_q[$];
    int m_lens[4];
    int m_ch, m_cnt;
    bit m_done;

    cfg_chain_loader #(
        .NUM_CHAINS(4),
        .WORD_W    (8),
        .LEN_W     (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_start  (cfg_start),
        .cfg_abort  (cfg_abort),
        .chain_len  (chain_len),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_last   (cfg_last),
        .cfg_ready  (cfg_ready),
        .bit_out    (bit_out),
        .chain_shift(chain_shift),
        .prgm_b     (prgm_b),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (chain_shift != 4'b0) begin
                logic [2:0] e;
                mon_shifts++;
                last_shift_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_shift", 32'(chain_shift), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("shift_chain", 32'(chain_shift), 32'd1 << e[2:1]);
                    check_eq("shift_bit", 32'(bit_out), e[0] ? (32'd1 << e[2:1]) : 32'd0);
                end
            end else if (busy) begin
                mon_stalls++;
            end
        end
    end

    task automatic model_start(input logic [63:0] lens);
        m_cnt  = 0;
        m_ch   = 0;
        m_done = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            m_lens[i] = int'(lens[i*16 +: 16]);
            if (m_lens[i] != 0) begin
                m_ch   = i;
                m_done = 1'b0;
            end
        end
    endtask

    task automatic model_word(input logic [7:0] w);
        for (int b = 7; b >= 0; b--) begin
            if (!m_done) begin
                int nxt;
                exp_q.push_back({2'(m_ch), w[b]});
                m_cnt++;
                if (m_cnt == m_lens[m_ch]) begin
                    m_cnt = 0;
                    nxt   = -1;
                    for (int j = m_ch + 1; j < 4; j++)
                        if (m_lens[j] != 0 && nxt < 0) nxt = j;
                    if (nxt < 0) m_done = 1'b1;
                    else m_ch = nxt;
                end
            end
        end
    endtask

    task automatic start_load(input logic [63:0] lens);
        chain_len   = lens;
        model_start(lens);
        base_shifts = mon_shifts;
        base_stalls = mon_stalls;
        cfg_start   = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input bit last);
        bit acc = 1'b0;
        model_word(d);
        cfg_data  = d;
        cfg_last  = last;
        cfg_valid = 1'b1;
        #1;
        for (int i = 0; i < 60 && !acc; i++) begin
            acc = cfg_ready;
            @(posedge clk);
            #1;
        end
        check_eq("word_accepted", 32'(acc), 32'd1);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic wait_for(input bit want_err, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = want_err ? err : done;
        end
        check_eq(tag, 32'(hit), 32'd1);
    endtask

    task automatic wait_shifts(input int n, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            #1;
            hit = (mon_shifts - base_shifts) >= n;
        end
        check_eq(tag, 32'(hit), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_prgm_b"}, 32'(prgm_b), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
        check_eq({tag, "_ready"}, 32'(cfg_ready), 32'd0);
        check_eq({tag, "_shift"}, 32'(chain_shift), 32'd0);
        check_eq({tag, "_bit_out"}, 32'(bit_out), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; chain_len = '0;
        cfg_data = '0; cfg_valid = 1'b0; cfg_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back words, chain 2 skipped.
        start_load(L1);
        send_word(8'hA5, 1'b0);
        send_word(8'h3C, 1'b1);
        wait_for(1'b0, "t1_done");
        check_eq("t1_prgm_b", 32'(prgm_b), 32'd1);
        check_eq("t1_done_latency", 32'(cyc - last_shift_cyc), 32'd1);
        check_eq("t1_shifts", 32'(mon_shifts - base_shifts), 32'd16);
        check_eq("t1_stalls", 32'(mon_stalls - base_stalls), 32'd1);
        check_eq("t1_queue", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check_eq("t1_done_pulse", 32'(done), 32'd0);
        check_eq("t1_prgm_hold", 32'(prgm_b), 32'd1);
        check_eq("t1_ready_done", 32'(cfg_ready), 32'd0);

        // Restart from DONE with a 5-cycle gap after the first word drains.
        start_load(L1);
        @(negedge clk);
        check_eq("t2_prgm_low", 32'(prgm_b), 32'd0);
        check_eq("t2_busy", 32'(busy), 32'd1);
        send_word(8'hA5, 1'b0);
        repeat (8) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t2_gap_noshift", 32'(chain_shift), 32'd0);
        end
        send_word(8'h3C, 1'b1);
        wait_for(1'b0, "t2_done");
        check_eq("t2_shifts", 32'(mon_shifts - base_shifts), 32'd16);
        check_eq("t2_queue", 32'(exp_q.size()), 32'd0);

        // Stream too short: last word runs out after 8 bits.
        start_load(L3);
        send_word(8'hA5, 1'b1);
        wait_for(1'b1, "t3_err");
        check_eq("t3_err_latency", 32'(cyc - last_shift_cyc), 32'd1);
        check_eq("t3_prgm_b", 32'(prgm_b), 32'd0);
        check_eq("t3_ready", 32'(cfg_ready), 32'd0);
        check_eq("t3_busy", 32'(busy), 32'd0);
        check_eq("t3_shifts", 32'(mon_shifts - base_shifts), 32'd8);
        check_eq("t3_queue", 32'(exp_q.size()), 32'd0);

        // Abort after six bits, then a clean reload out of ERROR.
        start_load(L1);
        @(negedge clk);
        check_eq("t4_err_clear", 32'(err), 32'd0);
        send_word(8'hA5, 1'b0);
        wait_shifts(6, "t4_reach6");
        @(posedge clk);
        #1;
        cfg_abort = 1'b1;
        @(negedge clk);
        check_eq("t4_abort_noshift", 32'(chain_shift), 32'd0);
        @(posedge clk);
        #1;
        cfg_abort = 1'b0;
        @(negedge clk);
        #1;
        check_eq("t4_err", 32'(err), 32'd1);
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_prgm_b", 32'(prgm_b), 32'd0);
        check_eq("t4_shifts", 32'(mon_shifts - base_shifts), 32'd6);
        check_eq("t4_unshifted", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        start_load(L1);
        send_word(8'hA5, 1'b0);
        send_word(8'h3C, 1'b1);
        wait_for(1'b0, "t4_done");
        check_eq("t4_err_after", 32'(err), 32'd0);
        check_eq("t4_reload_shifts", 32'(mon_shifts - base_shifts), 32'd16);

        // All chains empty: done without accepting anything.
        start_load(64'd0);
        @(negedge clk);
        check_eq("t5_done", 32'(done), 32'd1);
        check_eq("t5_prgm_b", 32'(prgm_b), 32'd1);
        check_eq("t5_ready", 32'(cfg_ready), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("t5_done_pulse", 32'(done), 32'd0);
        check_eq("t5_shifts", 32'(mon_shifts - base_shifts), 32'd0);

        // Asynchronous reset mid-load, then a short load that discards surplus bits.
        start_load(L1);
        send_word(8'hA5, 1'b0);
        send_word(8'h3C, 1'b1);
        wait_shifts(10, "t6_reach10");
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t6_async");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        @(negedge clk);
        check_eq("t6_idle_prgm_b", 32'(prgm_b), 32'd0);
        @(posedge clk);
        #1;
        start_load(L6);
        send_word(8'hE0, 1'b1);
        wait_for(1'b0, "t6_done");
        check_eq("t6_shifts", 32'(mon_shifts - base_shifts), 32'd3);
        check_eq("t6_queue", 32'(exp_q.size()), 32'd0);
        check_eq("t6_prgm_b", 32'(prgm_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
Parametrised configuration controller that replaces the hand-wired per-resource programming pins (separate bit_in / prgm_b per CLB, CB and SB chain) of the fabric top level.
- Accepts a packed bitstream as words on a valid/ready stream.
- Serialises the words into NUM_CHAINS independent daisy-chained configuration shift chains, one chain at a time, each of programmable length.
- Drives the global prgm_b and reports completion or error.
- Sits between the external config port and the fabric top, feeding each chain's bit_in and shift-enable.

Parameters:
NUM_CHAINS, 4, number of config chains (e.g. CLB, CB, SB, SB_2); at least 1.
WORD_W, 8, bitstream input word width; at least 1.
LEN_W, 16, width of each per-chain bit-length field.

Ports:
clk  input  1  fabric clock.
reset  input  1  asynchronous, active-high reset.
cfg_start  input  1  one-cycle pulse that begins a load. Honoured in IDLE, DONE and ERROR.
cfg_abort  input  1  abandons a load in progress, leading to ERROR.
chain_len  input  NUM_CHAINS*LEN_W  bit count per chain; chain i occupies field [i*LEN_W +: LEN_W]. Sampled on cfg_start.
cfg_data  input  WORD_W  bitstream word; MSB is shifted first.
cfg_valid  input  1  cfg_data is valid.
cfg_last  input  1  marks the final word of the stream; qualified by cfg_valid.
cfg_ready  output  1  loader accepts the word this cycle.
bit_out  output  NUM_CHAINS  serial data, one bit per chain. Only the active chain is non-zero.
chain_shift  output  NUM_CHAINS  one-hot shift enable for the active chain; drives that chain's *_prgm_b.
prgm_b  output  1  0 = fabric in programming mode; 1 = configured/user mode.
busy  output  1  high while in LOAD.
done  output  1  one-cycle pulse on successful completion.
err  output  1  sticky error flag; cleared by cfg_start.

Behaviour:
Reset values: all outputs 0 (including prgm_b = 0, holding the fabric unconfigured). State = IDLE.

State machine:
- IDLE -> LOAD on cfg_start.
  - cfg_start latches chain_len into len_q.
  - Chain index idx becomes the first chain with a non-zero length.
  - prgm_b is forced to 0.
  - err is cleared.
  - If all lengths are 0, go directly to DONE instead; done pulses on the next cycle.
- LOAD: a word buffer holds up to WORD_W bits together with a count buf_cnt.
  - cfg_ready = (buf_cnt==0) || (buf_cnt==1 && shifting this cycle), so there is no bubble between words.
  - A word is accepted when cfg_valid && cfg_ready.
  - The first bit of an accepted word appears on bit_out[idx] with chain_shift[idx]=1 in the next cycle.
  - One bit is shifted per cycle while buf_cnt>0. When the buffer is empty, chain_shift is all 0 (stall; the chain holds).
  - A per-chain counter counts shifted bits. When it reaches len_q[idx], idx advances to the next chain with non-zero length.
  - Bits are packed continuously: a word may span a chain boundary, with no padding.
  - After the last bit of the last non-zero chain: remaining buffered bits are discarded, state goes to DONE, prgm_b rises to 1 in the following cycle, and done pulses in that same cycle.
  - If the word carrying cfg_last was accepted but its bits run out before all chains are full, go to ERROR.
  - If total bits finish while the accepted word was not the cfg_last word, this is not an error. Later words are not accepted; cfg_ready = 0 outside LOAD.
- cfg_abort in LOAD -> ERROR in the next cycle. Shifting stops immediately and the buffer is flushed.
- ERROR: err = 1, prgm_b = 0, busy = 0. Only cfg_start leaves this state.
- DONE: prgm_b stays 1 until the next cfg_start. cfg_start in DONE re-enters LOAD and drops prgm_b to 0 in the same edge.

Event ordering and reset:
- cfg_start has priority over cfg_abort in IDLE/DONE/ERROR. cfg_start is ignored in LOAD.
- cfg_abort takes priority over completion in the same cycle.
- Asynchronous reset mid-load returns to IDLE with every output 0. Partial chain contents are the fabric's concern.

Width rules:
- The counter is LEN_W bits wide, so the maximum chain length is 2^LEN_W-1.
- Buffer count is $clog2(WORD_W+1) bits.
- Chain index is $clog2(NUM_CHAINS) bits, with a minimum of 1.

Decomposition:
- Package cfg_loader_pkg holds:
  - state enum {IDLE, LOAD, DONE, ERROR};
  - a helper function next_nonzero_chain(len_vector, from_idx) that returns the index and a found flag.
- Sub-module cfg_word_serializer (parameter WORD_W) contains the buffer, buf_cnt, ready logic and MSB-first shift. The top level holds the FSM, per-chain counter and output demux.

Test Plan:
1. NUM_CHAINS=4, WORD_W=8, lens {3,5,0,8}; words 0xA5, 0x3C (last).
   - Chain0 gets 1,0,1.
   - Chain1 gets 0,0,1,0,1.
   - Chain2 is skipped.
   - Chain3 gets 0,0,1,1,1,1,0,0.
   - 16 consecutive shift cycles with no gap.
   - prgm_b = 1 and done pulses one cycle after the final bit.
2. Same lens; cfg_valid deasserted for 5 cycles between words -> chain_shift = 0 during the gap, bit order unchanged, done still occurs.
3. lens {4,4,4,4}; only 1 word sent, with cfg_last -> ERROR after 8 bits; err = 1, prgm_b = 0, cfg_ready = 0.
4. cfg_abort at bit 6 of scenario 1 -> no further chain_shift, err = 1 next cycle. Then cfg_start plus a full stream -> err clears and DONE is reached.
5. All lens = 0; cfg_start -> no shifts, done pulse, prgm_b = 1 without any word being accepted.
6. Assert reset mid-load at bit 10 -> all outputs 0 asynchronously, state IDLE. A subsequent full load succeeds. lens {1,0,0,2} with word 0xE0 -> chain0 gets 1, chain3 gets 1,1, and 5 bits are discarded.
